// File: rtl/tagged_mem_model_if.sv
// Processor-side bus of the tagged memory model: command/address/data in,
// acceptance tag and tagged load returns out.
interface tagged_mem_model_if #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 32,
  parameter int NUM_TAGS = 15
);
  localparam int TAG_W = $clog2(NUM_TAGS + 1);

  logic [1:0]        proc2mem_command;
  logic [ADDR_W-1:0] proc2mem_addr;
  logic [1:0]        proc2mem_size;
  logic [DATA_W-1:0] proc2mem_data;
  logic [TAG_W-1:0]  mem2proc_transaction_tag;
  logic [DATA_W-1:0] mem2proc_data;
  logic [TAG_W-1:0]  mem2proc_data_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data,
    input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data,
    output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
  );
endinterface

// File: rtl/tagged_mem_model.sv
// Tagged memory model: loads get the lowest free tag and return captured line
// data a fixed LATENCY later; stores write byte lanes immediately.
module tagged_mem_model #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 8192,
  parameter int LATENCY  = 4,
  parameter int NUM_TAGS = 15,
  localparam int TAG_W   = $clog2(NUM_TAGS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  tagged_mem_model_if.slave bus,
  output logic [TAG_W-1:0] outstanding,
  output logic             err_addr
);
  localparam int LANES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(LANES);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_STORE = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_e;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [TAG_W-1:0]  pipe_tag  [LATENCY];
  logic [DATA_W-1:0] pipe_data [LATENCY];
  logic [NUM_TAGS:1] busy;
  logic [TAG_W-1:0]  count;
  logic              err_q;

  cmd_e              cmd;
  logic [LINE_W-1:0] line;
  logic [OFF_W-1:0]  offset;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              is_load, is_store, accept, store_ok, misaligned;
  logic [TAG_W-1:0]  free_tag, ret_tag;
  logic [DATA_W-1:0] load_data, wdata;
  logic [LANES-1:0]  wmask;
  int unsigned       nbytes;

  assign cmd      = cmd_e'(bus.proc2mem_command);
  assign line     = bus.proc2mem_addr[ADDR_W-1:OFF_W];
  assign offset   = bus.proc2mem_addr[OFF_W-1:0];
  assign idx      = line[IDX_W-1:0];
  assign in_range = {1'b0, line} < (LINE_W + 1)'(DEPTH);
  assign is_load  = !reset && (cmd == CMD_LOAD);
  assign is_store = !reset && (cmd == CMD_STORE);
  assign ret_tag  = pipe_tag[LATENCY-1];

  // A tag returning this cycle counts as free so it can be reissued at once.
  always_comb begin
    free_tag = '0;
    for (int unsigned t = NUM_TAGS; t >= 1; t--) begin
      if (!busy[t] || ret_tag == TAG_W'(t)) free_tag = TAG_W'(t);
    end
  end

  assign accept    = is_load && (free_tag != '0);
  assign load_data = in_range ? mem[idx] : '0;

  always_comb begin
    case (bus.proc2mem_size)
      2'd0:    nbytes = 1;
      2'd1:    nbytes = 2;
      2'd2:    nbytes = 4;
      default: nbytes = LANES;
    endcase
    misaligned = (32'(offset) & (nbytes - 1)) != 0;
    store_ok   = is_store && in_range && !misaligned;
    wdata      = bus.proc2mem_data << {offset, 3'b000};
    for (int unsigned i = 0; i < LANES; i++) begin
      wmask[i] = (i >= 32'(offset)) && (i < 32'(offset) + nbytes);
    end
  end

  // Memory has no reset so preloaded contents survive it.
  always_ff @(posedge clock) begin
    if (store_ok) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_tag[0] <= accept ? free_tag : '0;
      for (int unsigned i = 1; i < LATENCY; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  always_ff @(posedge clock) begin
    pipe_data[0] <= load_data;
    for (int unsigned i = 1; i < LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy  <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned t = 1; t <= NUM_TAGS; t++) begin
        if (accept && free_tag == TAG_W'(t))  busy[t] <= 1'b1;
        else if (ret_tag == TAG_W'(t))        busy[t] <= 1'b0;
      end
      count <= count + TAG_W'(accept) - TAG_W'(ret_tag != '0);
      if ((accept && !in_range) || (is_store && (!in_range || misaligned)))
        err_q <= 1'b1;
    end
  end

  assign bus.mem2proc_transaction_tag = accept ? free_tag : '0;
  assign bus.mem2proc_data_tag        = reset ? '0 : ret_tag;
  assign bus.mem2proc_data            = (reset || ret_tag == '0) ? '0 : pipe_data[LATENCY-1];
  assign outstanding                  = reset ? '0 : count;
  assign err_addr                     = !reset && err_q;
endmodule

// File: tb/tb_tagged_mem_model.sv
// Directed bench for tagged_mem_model: a 15-tag instance for data paths and
// a 2-tag instance for tag exhaustion and same-cycle tag reuse.
module tb_tagged_mem_model;
  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] out_a;
  logic [1:0] out_b;
  logic       err_a, err_b;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  tagged_mem_model_if #(.DATA_W(64), .ADDR_W(32), .NUM_TAGS(15)) bus_a ();
  tagged_mem_model_if #(.DATA_W(64), .ADDR_W(32), .NUM_TAGS(2))  bus_b ();

  tagged_mem_model #(.DATA_W(64), .ADDR_W(32), .DEPTH(64), .LATENCY(4), .NUM_TAGS(15)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a), .outstanding(out_a), .err_addr(err_a));

  tagged_mem_model #(.DATA_W(64), .ADDR_W(32), .DEPTH(64), .LATENCY(4), .NUM_TAGS(2)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b), .outstanding(out_b), .err_addr(err_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cmd_a(input logic [1:0] c, input logic [31:0] a, input logic [1:0] s,
                       input logic [63:0] d);
    bus_a.proc2mem_command = c;
    bus_a.proc2mem_addr    = a;
    bus_a.proc2mem_size    = s;
    bus_a.proc2mem_data    = d;
    #1;
  endtask

  task automatic cmd_b(input logic [1:0] c);
    bus_b.proc2mem_command = c;
    bus_b.proc2mem_addr    = '0;
    bus_b.proc2mem_size    = '0;
    bus_b.proc2mem_data    = '0;
    #1;
  endtask

  task automatic store_a(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d);
    cmd_a(STORE, a, s, d);
    check("store_tag", 64'(bus_a.mem2proc_transaction_tag), 64'd0);
    tick();
    cmd_a(NONE, '0, '0, '0);
  endtask

  // Issue one load, then expect its return exactly four cycles later and nothing in between.
  task automatic load_check(input string name, input logic [31:0] a, input logic [3:0] exp_tag,
                            input logic [63:0] exp_data);
    cmd_a(LOAD, a, '0, '0);
    check({name, "_ttag"}, 64'(bus_a.mem2proc_transaction_tag), 64'(exp_tag));
    tick();
    cmd_a(NONE, '0, '0, '0);
    repeat (2) begin
      tick();
      check({name, "_early"}, 64'(bus_a.mem2proc_data_tag), 64'd0);
    end
    tick();
    check({name, "_dtag"}, 64'(bus_a.mem2proc_data_tag), 64'(exp_tag));
    check({name, "_data"}, bus_a.mem2proc_data, exp_data);
    tick();
    check({name, "_dtag_off"}, 64'(bus_a.mem2proc_data_tag), 64'd0);
    check({name, "_data_off"}, bus_a.mem2proc_data, 64'd0);
    check({name, "_outst"}, 64'(out_a), 64'd0);
  endtask

  initial begin
    cmd_a(NONE, '0, '0, '0);
    cmd_b(NONE);
    reset = 1'b1;
    tick();
    tick();
    // Commands during reset are ignored.
    cmd_a(LOAD, 32'h28, '0, '0);
    check("rst_ttag", 64'(bus_a.mem2proc_transaction_tag), 64'd0);
    check("rst_outst", 64'(out_a), 64'd0);
    check("rst_dtag", 64'(bus_a.mem2proc_data_tag), 64'd0);
    check("rst_data", bus_a.mem2proc_data, 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    tick();
    reset = 1'b0;
    cmd_a(NONE, '0, '0, '0);
    check("post_rst_outst", 64'(out_a), 64'd0);

    // Preload line 5 and read it back.
    store_a(32'h28, 2'd3, 64'h0123456789ABCDEF);
    load_check("ld5", 32'h28, 4'd1, 64'h0123456789ABCDEF);

    // Sub-line stores into line 0.
    store_a(32'h0, 2'd3, 64'h0);
    store_a(32'h3, 2'd0, 64'hAA);
    load_check("byte3", 32'h0, 4'd1, 64'h00000000AA000000);
    store_a(32'h0, 2'd1, 64'h1234);
    store_a(32'h4, 2'd2, 64'hCAFEF00D);
    store_a(32'h1, 2'd0, 64'hFFFFFF55);
    load_check("mixed", 32'h0, 4'd1, 64'hCAFEF00DAA005534);
    check("err_clean", 64'(err_a), 64'd0);

    // Misaligned word store is dropped and err_addr sticks.
    store_a(32'h2, 2'd2, 64'hDEADBEEF);
    check("misalign_err", 64'(err_a), 64'd1);
    load_check("misalign_mem", 32'h0, 4'd1, 64'hCAFEF00DAA005534);
    check("err_sticky", 64'(err_a), 64'd1);

    // Store behind a pending load must not change the captured data.
    cmd_a(LOAD, 32'h28, '0, '0);
    check("raw_ttag", 64'(bus_a.mem2proc_transaction_tag), 64'd1);
    tick();
    cmd_a(STORE, 32'h28, 2'd3, '1);
    check("raw_st_ttag", 64'(bus_a.mem2proc_transaction_tag), 64'd0);
    tick();
    cmd_a(NONE, '0, '0, '0);
    tick();
    tick();
    check("raw_dtag", 64'(bus_a.mem2proc_data_tag), 64'd1);
    check("raw_old", bus_a.mem2proc_data, 64'h0123456789ABCDEF);
    tick();
    load_check("raw_new", 32'h28, 4'd1, 64'hFFFFFFFFFFFFFFFF);

    // Reset with three loads in flight.
    cmd_a(LOAD, 32'h28, '0, '0);
    check("fl_t1", 64'(bus_a.mem2proc_transaction_tag), 64'd1);
    tick();
    cmd_a(LOAD, 32'h0, '0, '0);
    check("fl_t2", 64'(bus_a.mem2proc_transaction_tag), 64'd2);
    tick();
    cmd_a(LOAD, 32'h8, '0, '0);
    check("fl_t3", 64'(bus_a.mem2proc_transaction_tag), 64'd3);
    tick();
    cmd_a(NONE, '0, '0, '0);
    check("fl_outst", 64'(out_a), 64'd3);
    reset = 1'b1;
    #1;
    check("fl_rst_outst", 64'(out_a), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("fl_no_ret", 64'(bus_a.mem2proc_data_tag), 64'd0);
      tick();
    end
    check("fl_outst_after", 64'(out_a), 64'd0);
    check("fl_err_cleared", 64'(err_a), 64'd0);
    load_check("fl_mem5", 32'h28, 4'd1, 64'hFFFFFFFFFFFFFFFF);
    load_check("fl_mem0", 32'h0, 4'd1, 64'hCAFEF00DAA005534);

    // Out-of-range load: tagged, returns zero, flags error.
    load_check("oor_ld", 32'h200, 4'd1, 64'd0);
    check("oor_ld_err", 64'(err_a), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("oor_rst_err", 64'(err_a), 64'd0);
    // Out-of-range store must not alias onto line 0.
    store_a(32'h200, 2'd3, 64'h5555555555555555);
    check("oor_st_err", 64'(err_a), 64'd1);
    load_check("oor_st_mem", 32'h0, 4'd1, 64'hCAFEF00DAA005534);

    // Two-tag instance: exhaustion and reuse on the return cycle.
    cmd_b(LOAD);
    check("b_t1", 64'(bus_b.mem2proc_transaction_tag), 64'd1);
    tick();
    cmd_b(LOAD);
    check("b_t2", 64'(bus_b.mem2proc_transaction_tag), 64'd2);
    tick();
    cmd_b(LOAD);
    check("b_full", 64'(bus_b.mem2proc_transaction_tag), 64'd0);
    tick();
    cmd_b(LOAD);
    check("b_outst2", 64'(out_b), 64'd2);
    check("b_full2", 64'(bus_b.mem2proc_transaction_tag), 64'd0);
    tick();
    cmd_b(LOAD);
    check("b_ret1", 64'(bus_b.mem2proc_data_tag), 64'd1);
    check("b_reuse", 64'(bus_b.mem2proc_transaction_tag), 64'd1);
    tick();
    cmd_b(NONE);
    check("b_outst_same", 64'(out_b), 64'd2);
    check("b_ret2", 64'(bus_b.mem2proc_data_tag), 64'd2);
    tick();
    check("b_outst1", 64'(out_b), 64'd1);
    check("b_gap", 64'(bus_b.mem2proc_data_tag), 64'd0);
    tick();
    tick();
    check("b_ret1_again", 64'(bus_b.mem2proc_data_tag), 64'd1);
    tick();
    check("b_outst0", 64'(out_b), 64'd0);
    check("b_err", 64'(err_b), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tagged_mem_model.md
TAGGED_MEM_MODEL -- requirements
Module: tagged_mem_model

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning memory line width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter DEPTH, default 8192, meaning number of DATA_W lines.
REQ-004 SHALL have parameter LATENCY, default 4, meaning cycles from load acceptance to data return (>=1).
REQ-005 SHALL have parameter NUM_TAGS, default 15, meaning maximum outstanding loads; TAG_W = clog2(NUM_TAGS+1).
REQ-006 SHALL have port clock, input, 1, meaning system clock (rising edge).
REQ-007 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-008 SHALL have port proc2mem_command, input, 2, meaning 0=NONE, 1=LOAD, 2=STORE, 3=reserved (treated as NONE).
REQ-009 SHALL have port proc2mem_addr, input, ADDR_W, meaning byte address.
REQ-010 SHALL have port proc2mem_size, input, 2, meaning store size 0=byte, 1=half, 2=word, 3=full line.
REQ-011 SHALL have port proc2mem_data, input, DATA_W, meaning store data, right-aligned for sub-line sizes.
REQ-012 SHALL have port mem2proc_transaction_tag, output, TAG_W, meaning combinational acceptance tag (0 = rejected or not a load).
REQ-013 SHALL have port mem2proc_data, output, DATA_W, meaning returned load data.
REQ-014 SHALL have port mem2proc_data_tag, output, TAG_W, meaning tag of returned data (0 = none this cycle).
REQ-015 SHALL have port outstanding, output, TAG_W, meaning count of loads accepted but not yet returned.
REQ-016 SHALL have port err_addr, output, 1, meaning sticky flag for out-of-range or misaligned access.

Function
REQ-017 Line index SHALL be addr[ADDR_W-1:log2(DATA_W/8)], and byte lane SHALL be the low address bits.
REQ-018 On LOAD, when a tag is free, the block SHALL drive mem2proc_transaction_tag, in the same cycle, with the lowest free nonzero tag, and SHALL allocate that tag at the rising edge.
REQ-019 On LOAD with no free tag, the block SHALL drive transaction_tag=0; it SHALL take no other action, and the requester SHALL retry.
REQ-020 An accepted load SHALL capture the line contents at the acceptance edge.
REQ-021 The captured data SHALL appear on mem2proc_data with data_tag=the allocated tag exactly LATENCY cycles after acceptance, for one cycle only.
REQ-022 The tag SHALL be freed on the return cycle, and SHALL be reusable by a load in that same cycle.
REQ-023 At most one command SHALL be accepted per cycle, so returns never collide.
REQ-024 When no return is due, data_tag SHALL be 0 and mem2proc_data SHALL be 0.
REQ-025 A STORE SHALL write the addressed bytes at the rising edge, SHALL never be rejected, and SHALL return transaction_tag=0.
REQ-026 A STORE SHALL modify only the 1/2/4/line-bytes lanes selected by size and address.
REQ-027 A misaligned STORE (address not a multiple of its size) SHALL be ignored and SHALL set err_addr.
REQ-028 A LOAD or STORE with line index >= DEPTH SHALL set err_addr; such a load SHALL still be tagged and SHALL return 0, and such a store SHALL be ignored.
REQ-029 A store to a line with a pending load SHALL NOT alter that load's captured data.
REQ-030 outstanding SHALL increment on acceptance and decrement on return; simultaneous acceptance and return SHALL leave it unchanged.

Reset
REQ-031 While reset=1, the block SHALL clear the return pipeline, free all tags, and drive outstanding=0, data_tag=0, mem2proc_data=0 and err_addr=0; commands presented during reset SHALL be ignored.
REQ-032 Reset mid-operation SHALL discard in-flight loads with no return.
REQ-033 Memory array contents SHALL be retained across reset, to support preload via $readmemh before reset deassertion.

Verification
REQ-034 Bench SHALL cover: preload line 5 = 0x0123456789ABCDEF, then LOAD addr 0x28 -> transaction_tag=1 same cycle; 4 cycles later data=0x0123456789ABCDEF, data_tag=1.
REQ-035 Bench SHALL cover: NUM_TAGS=2, LATENCY=4, LOADs on 3 consecutive cycles -> tags 1, 2, 0; outstanding=2; the retry is accepted with tag 1 on the cycle tag 1 returns.
REQ-036 Bench SHALL cover: line 0 = 0, STORE size=0 addr 0x3 data 0xAA, then LOAD addr 0 -> returns 0x00000000AA000000.
REQ-037 Bench SHALL cover: STORE size=2 addr 0x2 -> memory unchanged, err_addr=1 and stays 1 until reset.
REQ-038 Bench SHALL cover: LOAD accepted, STORE 0xFF..FF to the same line next cycle -> load returns the old data, and a subsequent load returns 0xFF..FF.
REQ-039 Bench SHALL cover: 3 loads in flight, reset pulsed 1 cycle -> no data_tag ever returns, outstanding=0, and memory contents are unchanged.
